// File: rtl/reg_file_8x8.sv
// Purpose: 8x8 register file with one write port and two combinational read ports; optional write-to-read forwarding under REG_FILE_BYPASS_EN.
// Latency: reads are zero-cycle from the address inputs; writes land on the CLK rising edge.
// Backpressure: none; a write is accepted on every edge where WRITE=1 and RESET=1.
module reg_file_8x8 #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IN,
    input  logic [2:0] INADDRESS,
    input  logic       WRITE,
    input  logic [2:0] OUT1ADDRESS,
    input  logic [2:0] OUT2ADDRESS,
    output logic [7:0] OUT1,
    output logic [7:0] OUT2
);

    logic [7:0] regs [8];

    // A write is taken only when WRITE is a clean 1, so an X/Z WRITE leaves the array untouched.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forwarding is suppressed during reset so both ports keep showing RESET_VAL.
    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        if (RESET && WRITE && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end
    end

    always_comb begin
        OUT2 = regs[OUT2ADDRESS];
        if (RESET && WRITE && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end
    end
`else
    assign OUT1 = regs[OUT1ADDRESS];
    assign OUT2 = regs[OUT2ADDRESS];
`endif

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8; expected read values are queued as stimulus is driven and popped at each sample point.
module tb_reg_file_8x8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;

    logic       clk_run = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q [$];

    reg_file_8x8 #(.RESET_VAL(8'h00)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2)
    );

    always #5 CLK = clk_run ? ~CLK : CLK;

    // Queue both expected values, let the combinational read settle, then pop and compare.
    task automatic chk(input string tag, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp1;
        logic [7:0] exp2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        #1;
        exp1 = exp_q.pop_front();
        exp2 = exp_q.pop_front();
        tests_run++;
        assert (OUT1 === exp1) else begin
            tests_failed++;
            $error("FAIL %s OUT1 observed=%02h expected=%02h", tag, OUT1, exp1);
        end
        tests_run++;
        assert (OUT2 === exp2) else begin
            tests_failed++;
            $error("FAIL %s OUT2 observed=%02h expected=%02h", tag, OUT2, exp2);
        end
    endtask

    task automatic rd(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                      input logic [7:0] e1, input logic [7:0] e2);
        OUT1ADDRESS = a1;
        OUT2ADDRESS = a2;
        chk(tag, e1, e2);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        WRITE     = 1'b1;
        INADDRESS = a;
        IN        = d;
        @(posedge CLK);
        #1;
        WRITE     = 1'b0;
    endtask

    initial begin
        RESET       = 1'b1;
        WRITE       = 1'b0;
        IN          = 8'h00;
        INADDRESS   = 3'd0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd7;

        // Reset with the clock stopped must clear the array immediately.
        #2;
        RESET = 1'b0;
        rd("rst_noclk_0_7", 3'd0, 3'd7, 8'h00, 8'h00);
        rd("rst_noclk_3_5", 3'd3, 3'd5, 8'h00, 8'h00);

        // Writes are ignored while reset is held, including on the addressed port.
        clk_run   = 1'b1;
        WRITE     = 1'b1;
        INADDRESS = 3'd1;
        IN        = 8'hFF;
        repeat (2) @(posedge CLK);
        #1;
        rd("rst_write_ignored", 3'd1, 3'd1, 8'h00, 8'h00);
        WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        rd("post_rst_r1", 3'd1, 3'd2, 8'h00, 8'h00);

        write_reg(3'd3, 8'hA5);
        write_reg(3'd6, 8'h3C);
        rd("wr_r3_r6", 3'd3, 3'd6, 8'hA5, 8'h3C);
        rd("others_0_7", 3'd0, 3'd7, 8'h00, 8'h00);
        rd("others_2_5", 3'd2, 3'd5, 8'h00, 8'h00);

        // WRITE low must hold the register across several edges.
        write_reg(3'd2, 8'h11);
        WRITE     = 1'b0;
        INADDRESS = 3'd2;
        IN        = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        rd("hold_r2", 3'd2, 3'd3, 8'h11, 8'hA5);

        // Same-cycle read of the register being written.
        write_reg(3'd5, 8'h01);
        OUT1ADDRESS = 3'd5;
        OUT2ADDRESS = 3'd5;
        WRITE       = 1'b1;
        INADDRESS   = 3'd5;
        IN          = 8'h7E;
`ifdef REG_FILE_BYPASS_EN
        chk("same_cycle_before_edge", 8'h7E, 8'h7E);
`else
        chk("same_cycle_before_edge", 8'h01, 8'h01);
`endif
        @(posedge CLK);
        #1;
        WRITE = 1'b0;
        chk("same_cycle_after_edge", 8'h7E, 8'h7E);

        // Reset 1 ns ahead of a write edge wins and the write is lost.
        write_reg(3'd4, 8'h55);
        rd("r4_pre", 3'd4, 3'd4, 8'h55, 8'h55);
        WRITE     = 1'b1;
        INADDRESS = 3'd4;
        IN        = 8'hAA;
        @(negedge CLK);
        #4;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        rd("rst_held_fwd_off", 3'd4, 3'd3, 8'h00, 8'h00);
        WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        rd("r4_after_rst", 3'd4, 3'd6, 8'h00, 8'h00);

        // Sweep every register, then every read-address pair.
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 8'h10 + 8'(i));
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                rd($sformatf("sweep_%0d_%0d", i, j), 3'(i), 3'(j),
                   8'h10 + 8'(i), 8'h10 + 8'(j));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
